// File: rtl/rv_mem_wb.sv
// rv_mem_wb: memory-stage load/store unit driving a Wishbone B4 classic master.
// One access in flight at a time; misaligned/illegal accesses, bus errors and
// bus timeouts complete with an exception instead of stalling the pipeline.
module rv_mem_wb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_rd,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic [4:0]  o_rd,
    output logic        o_exc,
    output logic [1:0]  o_exc_cause,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err
);

    localparam int unsigned CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_ALIGN = 2'd1;
    localparam logic [1:0] CAUSE_BUS   = 2'd2;
    localparam logic [1:0] CAUSE_TMO   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       lane_q, lane_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       cause_q, cause_d;
    logic             exc_q, exc_d;

    logic             bad_c;
    logic [3:0]       sel_c;
    logic [31:0]      dat_c;
    logic [31:0]      shifted_c;
    logic [31:0]      load_c;

    // Request decode: legality check and byte-lane placement of the store data.
    always_comb begin
        bad_c = 1'b0;
        sel_c = 4'b1111;
        dat_c = i_wdata;
        if (i_we) begin
            if (i_funct3 > 3'd2) bad_c = 1'b1;
        end else begin
            if (i_funct3 inside {3'd3, 3'd6, 3'd7}) bad_c = 1'b1;
        end
        case (i_funct3[1:0])
            2'd0: begin
                sel_c = 4'b0001 << i_addr[1:0];
                dat_c = {4{i_wdata[7:0]}};
            end
            2'd1: begin
                sel_c = i_addr[1] ? 4'b1100 : 4'b0011;
                dat_c = {2{i_wdata[15:0]}};
                if (i_addr[0]) bad_c = 1'b1;
            end
            default: begin
                sel_c = 4'b1111;
                dat_c = i_wdata;
                if (i_addr[1:0] != 2'b00) bad_c = 1'b1;
            end
        endcase
    end

    // Load alignment and sign/zero extension of the returned bus word.
    always_comb begin
        shifted_c = i_wb_dat >> {lane_q, 3'b000};
        case (f3_q)
            3'd0:    load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'd1:    load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'd4:    load_c = {24'd0, shifted_c[7:0]};
            3'd5:    load_c = {16'd0, shifted_c[15:0]};
            default: load_c = shifted_c;
        endcase
    end

    // Next-state and datapath update for IDLE -> BUS -> DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        rd_d    = rd_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        cause_d = cause_q;
        exc_d   = exc_q;
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    we_d    = i_we;
                    f3_d    = i_funct3;
                    lane_d  = i_addr[1:0];
                    rd_d    = i_rd;
                    adr_d   = {i_addr[31:2], 2'b00};
                    dat_d   = dat_c;
                    sel_d   = sel_c;
                    rdata_d = 32'd0;
                    cnt_d   = '0;
                    if (bad_c) begin
                        cause_d = CAUSE_ALIGN;
                        exc_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cause_d = CAUSE_NONE;
                        exc_d   = 1'b0;
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (i_wb_err) begin
                    cause_d = CAUSE_BUS;
                    exc_d   = 1'b1;
                    state_d = S_DONE;
                end else if (i_wb_ack) begin
                    rdata_d = we_q ? 32'd0 : load_c;
                    state_d = S_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TMO_LAST))) begin
                    cause_d = CAUSE_TMO;
                    exc_d   = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            lane_q  <= 2'd0;
            rd_q    <= 5'd0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            rdata_q <= 32'd0;
            cause_q <= 2'd0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            rd_q    <= rd_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            cause_q <= cause_d;
            exc_q   <= exc_d;
        end
    end

    assign o_busy      = ((state_q == S_IDLE) && i_req) || (state_q == S_BUS);
    assign o_done      = (state_q == S_DONE);
    assign o_rdata     = rdata_q;
    assign o_rd        = rd_q;
    assign o_exc       = exc_q;
    assign o_exc_cause = cause_q;
    assign o_wb_cyc    = (state_q == S_BUS);
    assign o_wb_stb    = (state_q == S_BUS);
    assign o_wb_we     = we_q;
    assign o_wb_adr    = adr_q;
    assign o_wb_dat    = dat_q;
    assign o_wb_sel    = sel_q;

endmodule

// File: tb/tb_rv_mem_wb.sv
// tb_rv_mem_wb: directed scoreboard bench for rv_mem_wb.
module tb_rv_mem_wb;

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        exc;
        logic [1:0]  cause;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, req0 = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0, wb_rdat = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        ack = 1'b0, err = 1'b0;

    logic        busy, done, exc, cyc, stb, wb_we;
    logic [31:0] rdata, adr, wb_wdat;
    logic [4:0]  rd_o;
    logic [1:0]  cause;
    logic [3:0]  sel;

    logic        busy0, done0, exc0, cyc0, stb0, wb_we0;
    logic [31:0] rdata0, adr0, wb_wdat0;
    logic [4:0]  rd_o0;
    logic [1:0]  cause0;
    logic [3:0]  sel0;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rv_mem_wb #(.TIMEOUT(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_we(we), .i_funct3(f3),
        .i_addr(addr), .i_wdata(wdata), .i_rd(rd),
        .o_busy(busy), .o_done(done), .o_rdata(rdata), .o_rd(rd_o),
        .o_exc(exc), .o_exc_cause(cause),
        .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(wb_we), .o_wb_adr(adr),
        .o_wb_dat(wb_wdat), .o_wb_sel(sel),
        .i_wb_dat(wb_rdat), .i_wb_ack(ack), .i_wb_err(err)
    );

    // Second instance with the timeout disabled, attached to a silent slave.
    rv_mem_wb #(.TIMEOUT(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_req(req0), .i_we(1'b0), .i_funct3(3'd2),
        .i_addr(32'h0000_0400), .i_wdata(32'd0), .i_rd(5'd1),
        .o_busy(busy0), .o_done(done0), .o_rdata(rdata0), .o_rd(rd_o0),
        .o_exc(exc0), .o_exc_cause(cause0),
        .o_wb_cyc(cyc0), .o_wb_stb(stb0), .o_wb_we(wb_we0), .o_wb_adr(adr0),
        .o_wb_dat(wb_wdat0), .o_wb_sel(sel0),
        .i_wb_dat(32'd0), .i_wb_ack(1'b0), .i_wb_err(1'b0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completion pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("rd", 32'(rd_o), 32'(e.rd));
                chk("exc", 32'(exc), 32'(e.exc));
                chk("cause", 32'(cause), 32'(e.cause));
                chk("busy_in_done", 32'(busy), 32'd0);
            end
        end
        if (done0 === 1'b1) chk("dut0_unexpected_done", 32'(done0), 32'd0);
    end

    // mode: 0 ack, 1 err, 2 ack+err, 3 silent slave, 4 rejected without bus cycle
    task automatic run(input logic t_we, input logic [2:0] t_f3, input logic [31:0] t_addr,
                       input logic [31:0] t_wdata, input logic [4:0] t_rd, input int mode,
                       input int waits, input logic [31:0] bus_data,
                       input logic [31:0] e_adr, input logic [3:0] e_sel, input logic [31:0] e_dat,
                       input logic [31:0] e_rdata, input logic [1:0] e_cause);
        exp_t e;
        int   n;
        @(negedge clk);
        req = 1'b1; we = t_we; f3 = t_f3; addr = t_addr; wdata = t_wdata; rd = t_rd;
        e.rdata = e_rdata; e.rd = t_rd; e.exc = (e_cause != 2'd0); e.cause = e_cause;
        sb.push_back(e);
        #1 chk("busy_on_req", 32'(busy), 32'd1);
        @(negedge clk);
        req = 1'b0;
        if (mode == 4) begin
            chk("no_cyc_rejected", 32'(cyc), 32'd0);
            return;
        end
        chk("cyc", 32'(cyc), 32'd1);
        chk("stb", 32'(stb), 32'd1);
        chk("busy_in_bus", 32'(busy), 32'd1);
        chk("adr", adr, e_adr);
        chk("sel", 32'(sel), 32'(e_sel));
        chk("we", 32'(wb_we), 32'(t_we));
        if (t_we) chk("wdat", wb_wdat, e_dat);
        repeat (waits) begin
            @(negedge clk);
            chk("cyc_held", 32'(cyc), 32'd1);
        end
        if (mode == 3) begin
            n = 1;
            while (n < 50) begin
                @(negedge clk);
                if (cyc) n++;
                else break;
            end
            chk("timeout_cyc_cycles", 32'(n), 32'd4);
        end else begin
            wb_rdat = bus_data;
            ack = (mode != 1);
            err = (mode != 0);
            @(negedge clk);
            ack = 1'b0;
            err = 1'b0;
            chk("cyc_low_in_done", 32'(cyc), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rd", 32'(rd_o), 32'd0);
        chk("rst_exc", 32'(exc), 32'd0);
        chk("rst_cause", 32'(cause), 32'd0);
        chk("rst_cyc_stb", 32'({cyc, stb}), 32'd0);
        chk("rst_we", 32'(wb_we), 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_dat", wb_wdat, 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        rst = 1'b0;

        //   we    f3    addr          wdata         rd  mode w bus_data      e_adr         sel      e_dat         e_rdata       cause
        run(1'b0, 3'd2, 32'h0000_0100, 32'h0,        5'd7, 0, 1, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF, 2'd0);
        run(1'b0, 3'd0, 32'h0000_0103, 32'h0,        5'd3, 0, 0, 32'h80FF_0000, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80, 2'd0);
        run(1'b0, 3'd4, 32'h0000_0103, 32'h0,        5'd4, 0, 0, 32'h80FF_0000, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0080, 2'd0);
        run(1'b0, 3'd1, 32'h0000_0102, 32'h0,        5'd5, 0, 2, 32'h80FF_0000, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF_80FF, 2'd0);
        run(1'b0, 3'd5, 32'h0000_0100, 32'h0,        5'd6, 0, 0, 32'h1234_8001, 32'h0000_0100, 4'b0011, 32'h0,        32'h0000_8001, 2'd0);
        run(1'b1, 3'd0, 32'h0000_0201, 32'h0000_00A5, 5'd0, 0, 0, 32'hFFFF_FFFF, 32'h0000_0200, 4'b0010, 32'hA5A5_A5A5, 32'h0,        2'd0);
        run(1'b1, 3'd1, 32'h0000_0202, 32'h0000_1234, 5'd0, 0, 1, 32'hFFFF_FFFF, 32'h0000_0200, 4'b1100, 32'h1234_1234, 32'h0,        2'd0);
        run(1'b1, 3'd2, 32'h0000_0204, 32'hCAFE_F00D, 5'd0, 0, 0, 32'h0,        32'h0000_0204, 4'b1111, 32'hCAFE_F00D, 32'h0,        2'd0);
        run(1'b0, 3'd2, 32'h0000_0102, 32'h0,        5'd9, 4, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        2'd1);
        run(1'b1, 3'd3, 32'h0000_0100, 32'h0,        5'd0, 4, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        2'd1);
        run(1'b0, 3'd6, 32'h0000_0100, 32'h0,        5'd2, 4, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        2'd1);
        run(1'b0, 3'd1, 32'h0000_0101, 32'h0,        5'd8, 4, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        2'd1);
        run(1'b0, 3'd2, 32'h0000_0300, 32'h0,        5'd10, 2, 0, 32'h1111_1111, 32'h0000_0300, 4'b1111, 32'h0,       32'h0,        2'd2);
        run(1'b1, 3'd2, 32'h0000_0308, 32'h5555_AAAA, 5'd0, 1, 1, 32'h0,       32'h0000_0308, 4'b1111, 32'h5555_AAAA, 32'h0,        2'd2);
        run(1'b0, 3'd2, 32'h0000_0310, 32'h0,        5'd11, 3, 0, 32'h0,        32'h0000_0310, 4'b1111, 32'h0,        32'h0,        2'd3);

        // Reset while in BUS: cycle dropped, no completion.
        @(negedge clk);
        req = 1'b1; we = 1'b0; f3 = 3'd2; addr = 32'h0000_0500; rd = 5'd12;
        @(negedge clk);
        req = 1'b0;
        chk("pre_reset_cyc", 32'(cyc), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_bus_cyc", 32'(cyc), 32'd0);
        chk("reset_bus_stb", 32'(stb), 32'd0);
        chk("reset_bus_busy", 32'(busy), 32'd0);
        chk("reset_bus_done", 32'(done), 32'd0);
        rst = 1'b0;
        run(1'b0, 3'd2, 32'h0000_0600, 32'h0, 5'd13, 0, 0, 32'h0BAD_F00D, 32'h0000_0600, 4'b1111, 32'h0, 32'h0BAD_F00D, 2'd0);

        // Timeout disabled: cycle must be held indefinitely.
        @(negedge clk);
        req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        n = 0;
        repeat (1000) begin
            if (cyc0 && stb0 && busy0) n++;
            @(negedge clk);
        end
        chk("no_timeout_held_cycles", 32'(n), 32'd1000);

        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
